// File: rtl/uart_button_rx.sv
// UART command receiver: 8N1 deserialiser that maps the a/d/w/s keys to one-hot button pulses.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 with a parity check.
module uart_button_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] button,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       button_q, button_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rxs_q;
  logic             par_ok_c;

  // Key decode: upper and lower case map to the same command
  function automatic logic [3:0] decode(input logic [7:0] b);
    case (b)
      8'h64, 8'h44: return 4'b0001;
      8'h61, 8'h41: return 4'b1000;
      8'h77, 8'h57: return 4'b0100;
      8'h73, 8'h53: return 4'b0010;
      default:      return 4'b0000;
    endcase
  endfunction

  // Two-flop synchroniser, idles high like the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  // Even parity: data bits plus parity bit must XOR to zero
  assign par_ok_c = ~(^{shift_q, par_q});
`else
  assign par_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      button_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      button_q <= button_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    button_d = 4'b0000;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = CNT_FULL;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = CNT_FULL;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          par_d   = rxs_q;
          cnt_d   = CNT_FULL;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        // Sample mid-stop and return to IDLE at once so a back-to-back start bit is caught
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (rxs_q && par_ok_c) begin
            data_d   = shift_q;
            valid_d  = 1'b1;
            button_d = decode(shift_q);
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign button    = button_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_button_rx.sv
// Self-checking bench for uart_button_rx: serial frames are driven bit by bit and the
// output pulses are compared against a frame-level model of expected events.
`timescale 1ns/1ps
module tb_uart_button_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  // From the start-bit falling edge to the output pulse: 2 sync cycles, half a bit,
  // the remaining bit periods up to the stop sample, then one register stage.
  localparam int LAT = 2 + C / 2 + (NB - 1) * C + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] button;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  uart_button_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .button(button), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  btn;
    logic        v;
    logic        fe;
    logic [7:0]  data;
  } ev_t;

  ev_t        obs[$];
  ev_t        exq[$];
  logic [7:0] mdata = 8'h00;
  int         total = 0;
  int         bad = 0;

  // Record every cycle in which any output pulse is active
  always @(negedge clk) begin
    if (button !== 4'b0000 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      ev_t e;
      e.cyc = 32'(cyc); e.btn = button; e.v = rx_valid; e.fe = frame_err; e.data = rx_data;
      obs.push_back(e);
    end
  end

  function automatic logic [3:0] key_code(input logic [7:0] b);
    logic [7:0] lc;
    lc = b | 8'h20;
    case (lc)
      8'h64:   return 4'b0001;
      8'h61:   return 4'b1000;
      8'h77:   return 4'b0100;
      8'h73:   return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  // Drive one frame starting at the current negedge and queue the event it should produce
  task automatic send(input logic [7:0] b, input bit stop, input bit badpar);
    int  k;
    bit  ok;
    ev_t e;
    k  = cyc;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    if (PAR) begin
      rx = (^b) ^ badpar;
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    ok = stop && !(PAR && badpar);
    e.cyc  = 32'(k + LAT);
    e.btn  = ok ? key_code(b) : 4'b0000;
    e.v    = ok;
    e.fe   = !ok;
    e.data = ok ? b : mdata;
    if (ok) mdata = b;
    exq.push_back(e);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    total++; if (button !== 4'b0000) begin bad++; $display("FAIL reset_button got=%b want=0000", button); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    rst_n = 1'b1;
    idle(C);
  endtask

  task automatic test_single_keys();
    obs.delete(); exq.delete();
    send(8'h64, 1'b1, 1'b0); idle(C);
    send(8'h7A, 1'b1, 1'b0); idle(2 * C);
    total++; if (obs.size() !== exq.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL single_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [4];
    msg[0] = 8'h61; msg[1] = 8'h57; msg[2] = 8'h73; msg[3] = 8'h44;
    obs.delete(); exq.delete();
    for (int i = 0; i < 4; i++) send(msg[i], 1'b1, 1'b0);
    idle(2 * C);
    total++; if (obs.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", obs.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL b2b_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
    if (obs.size() == 4) begin
      total++;
      if (int'(obs[3].cyc - obs[0].cyc) !== 3 * NB * C) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=%0d", int'(obs[3].cyc - obs[0].cyc), 3 * NB * C);
      end
    end
  endtask

  task automatic test_frame_err();
    obs.delete(); exq.delete();
    send(8'h41, 1'b0, 1'b0); idle(2 * C);
    send(8'h77, 1'b1, 1'b0); idle(C);
    if (PAR) begin
      send(8'h64, 1'b1, 1'b1); idle(C);
    end
    total++; if (obs.size() !== exq.size()) begin bad++; $display("FAIL ferr_count got=%0d want=%0d", obs.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL ferr_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
  endtask

  task automatic test_glitch();
    obs.delete(); exq.delete();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * C);
    send(8'h73, 1'b1, 1'b0); idle(C);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", obs.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL glitch_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h64;
    obs.delete(); exq.delete();
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = b[4];
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    mdata = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (button !== 4'b0000 || rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midreset_outputs got btn=%b v=%b fe=%b data=%h want all zero", button, rx_valid, frame_err, rx_data);
    end
    rst_n = 1'b1;
    idle(C);
    send(8'h61, 1'b1, 1'b0); idle(C);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL midreset_count got=%0d want=1", obs.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL midreset_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] keys [8];
    logic [7:0] b;
    bit         stop, badpar;
    keys[0] = 8'h61; keys[1] = 8'h64; keys[2] = 8'h77; keys[3] = 8'h73;
    keys[4] = 8'h41; keys[5] = 8'h44; keys[6] = 8'h57; keys[7] = 8'h53;
    obs.delete(); exq.delete();
    for (int n = 0; n < 24; n++) begin
      b      = ($urandom_range(0, 1) == 0) ? keys[$urandom_range(0, 7)] : 8'($urandom);
      stop   = ($urandom_range(0, 7) != 0);
      badpar = ($urandom_range(0, 7) == 0);
      send(b, stop, badpar);
      if (!stop) idle(2 * C);
      else       idle($urandom_range(0, C));
    end
    idle(2 * C);
    total++; if (obs.size() !== exq.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs.size(), exq.size()); end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exq[i]) begin
        bad++;
        $display("FAIL rand_ev%0d got cyc=%0d btn=%b v=%b fe=%b data=%h want cyc=%0d btn=%b v=%b fe=%b data=%h", i,
                 obs[i].cyc, obs[i].btn, obs[i].v, obs[i].fe, obs[i].data, exq[i].cyc, exq[i].btn, exq[i].v, exq[i].fe, exq[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_keys();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
